// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver with mid-bit sampling feeding a first-word-fall-through FIFO.
// Handshake: a byte leaves the FIFO on any clock edge where rx_valid_o && rx_ready_i.
module uart_rx_buffered #(
  parameter int ClockFrequency = 125_000_000,
  parameter int BaudRate       = 15_625_000,
  parameter int FifoDepth      = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           rx_i,
  output logic [7:0]                     rx_data_o,
  output logic                           rx_valid_o,
  input  logic                           rx_ready_i,
  output logic [$clog2(FifoDepth+1)-1:0] rx_level_o,
  output logic                           busy_o,
  output logic                           frame_err_o,
  output logic                           overflow_o
);

  localparam int ClksPerBit = ClockFrequency / BaudRate;
  localparam int HalfBit    = ClksPerBit / 2;
  localparam int CntW       = $clog2(ClksPerBit);
  localparam int PtrW       = $clog2(FifoDepth);
  localparam int LvlW       = $clog2(FifoDepth + 1);

  localparam logic [CntW-1:0] CntLast = CntW'(ClksPerBit - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(HalfBit - 1);
  localparam logic [LvlW-1:0] LvlFull = LvlW'(FifoDepth);

  if (ClksPerBit < 4) begin : g_clks_check
    $error("uart_rx_buffered: ClockFrequency/BaudRate must be at least 4");
  end

  if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_depth_check
    $error("uart_rx_buffered: FifoDepth must be a power of two and at least 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  // Receiver state
  logic            sync1_q, sync2_q;
  logic [1:0]      fill_q;
  logic            armed_q;
  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      idx_q;
  logic [7:0]      shift_q;
  logic            frame_err_q;
  logic            rxs;
  logic            stop_sample;
  logic            push_valid;

  // FIFO state
  logic [7:0]      mem_q [FifoDepth];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LvlW-1:0] count_q, count_d;
  logic            overflow_q;
  logic            full;
  logic            pop;
  logic            push_acc;

  assign rxs         = sync2_q;
  assign stop_sample = (state_q == ST_STOP) && (cnt_q == CntLast);
  assign push_valid  = stop_sample && rxs;

  // The synchronizer resets to 1, which is not an observation of the line.
  // fill_q marks when sync2_q holds a real sample, so arming needs a genuine high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      fill_q      <= 2'b00;
      armed_q     <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      sync1_q     <= rx_i;
      sync2_q     <= sync1_q;
      fill_q      <= {fill_q[0], 1'b1};
      frame_err_q <= 1'b0;
      if (fill_q[1] && rxs) begin
        armed_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (armed_q && !rxs) begin
            state_q <= ST_START;
            cnt_q   <= '0;
          end
        end
        ST_START: begin
          if (cnt_q == CntHalf) begin
            cnt_q <= '0;
            if (!rxs) begin
              state_q <= ST_DATA;
              idx_q   <= '0;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt_q == CntLast) begin
            shift_q <= {rxs, shift_q[7:1]};
            cnt_q   <= '0;
            idx_q   <= idx_q + 1'b1;
            if (idx_q == 3'd7) begin
              state_q <= ST_STOP;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_STOP: begin
          // Leave at mid stop bit so the next start edge is seen without delay.
          if (cnt_q == CntLast) begin
            frame_err_q <= !rxs;
            cnt_q       <= '0;
            state_q     <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign full       = (count_q == LvlFull);
  assign rx_valid_o = (count_q != '0);
  assign pop        = rx_valid_o && rx_ready_i;
  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign push_acc   = push_valid && (!full || pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    case ({push_acc, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < FifoDepth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= push_valid && !push_acc;
      if (push_acc) begin
        mem_q[wr_ptr_q] <= shift_q;
      end
    end
  end

  assign rx_data_o   = mem_q[rd_ptr_q];
  assign rx_level_o  = count_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign frame_err_o = frame_err_q;
  assign overflow_o  = overflow_q;

endmodule

// File: doc/uart_rx_buffered.md
# uart_rx_buffered

Synthesizable UART receiver with a small output FIFO, used inside the multicore system to receive the host-to-system serial stream driven onto `uart_rx_i` by the simulation UART model or an external adapter. It synchronizes the line, detects and validates start bits, samples 8N1 frames at mid-bit, and pushes good bytes into a first-word-fall-through FIFO drained through a valid/ready interface. Framing errors and overflow are reported as single-cycle pulses.

## Interface
- `ClockFrequency`, 125_000_000, system clock in Hz.
- `BaudRate`, 15_625_000, line rate in bit/s; `ClksPerBit = ClockFrequency/BaudRate`, must be >= 4 (elaboration error otherwise).
- `FifoDepth`, 4, FIFO entries; power of two, >= 2.
- `clk_i` in 1: system clock.
- `rst_i` in 1: synchronous active-high reset.
- `rx_i` in 1: asynchronous serial line, idle high.
- `rx_data_o` out 8: FIFO head byte, valid when `rx_valid_o`=1.
- `rx_valid_o` out 1: FIFO non-empty.
- `rx_ready_i` in 1: consumer accepts head when `rx_valid_o && rx_ready_i`.
- `rx_level_o` out $clog2(FifoDepth+1): current FIFO occupancy.
- `busy_o` out 1: receiver FSM not in IDLE.
- `frame_err_o` out 1: one-cycle pulse, stop bit sampled low.
- `overflow_o` out 1: one-cycle pulse, good byte dropped because FIFO full.

## Operation
- Synchronizer: two flops on `rx_i`, both reset to 1; FSM uses stage-2 output `rxs`.
- Arming: after reset, FSM ignores the line until `rxs`=1 for one cycle (`armed` flag); prevents false start when reset releases mid-frame.
- `HalfBit = ClksPerBit/2` (integer division); bit counter width $clog2(ClksPerBit).
- IDLE: if armed and `rxs`=0 -> START, counter=0.
- START: counter increments; at counter==HalfBit-1 sample `rxs`: 0 -> DATA, counter=0, bit index=0; 1 -> glitch, back to IDLE, nothing reported.
- DATA: at counter==ClksPerBit-1 sample `rxs` into shift register LSB first, counter=0, index++; after index 7 sampled -> STOP.
- STOP: at counter==ClksPerBit-1 sample `rxs`: 1 -> push byte; 0 -> `frame_err_o` pulse next cycle, byte discarded. Either way -> IDLE same edge (mid stop bit), so next falling edge is detected immediately.
- Push accepted if FIFO not full, or full with a pop in the same cycle; otherwise byte dropped and `overflow_o` pulses.
- Simultaneous push and pop on empty FIFO: head becomes the new byte, level stays 0->1 (pop of invalid head is ignored since `rx_valid_o`=0).
- FIFO: read/write pointers wrap modulo FifoDepth; occupancy counter in range 0..FifoDepth; FWFT, `rx_data_o` = mem[rd_ptr].
- `rx_data_o` and `rx_valid_o` stable while `rx_valid_o && !rx_ready_i`.
- `busy_o` = state != IDLE.

## Timing
- Reset values: `rx_valid_o`=0, `rx_level_o`=0, `busy_o`=0, `frame_err_o`=0, `overflow_o`=0, `rx_data_o`=0; FIFO emptied; FSM IDLE; armed=0; partial frame discarded.
- Reset mid-frame aborts the frame; no error pulse generated.
- Start detect: `rx_i` low at edge t -> `rxs` low after edge t+2 -> START entered at edge t+3.
- Stop sample at START entry + HalfBit + 9*ClksPerBit cycles; push written that edge; `rx_valid_o` high the next cycle if FIFO was empty.
- `frame_err_o`/`overflow_o` asserted exactly one cycle, the cycle after the stop sample.
- Pop: on edge with valid&&ready, rd_ptr advances; next head visible following cycle.
- Accepts back-to-back frames with 1-bit stop; baud mismatch tolerance ±(HalfBit-1)/(10*ClksPerBit).

## Test plan
- ClksPerBit=8, send 0xA5 8N1, `rx_ready_i`=0 -> `rx_valid_o`=1, `rx_data_o`=0xA5, level 1, held until ready pulses; then valid=0, level 0.
- Low glitch of 3 cycles on idle line -> no push, no error, `busy_o` high ~HalfBit cycles then 0.
- Send 0x3C with stop bit 0 -> one `frame_err_o` pulse, level stays 0; following good 0x7E received normally.
- 5 bytes 0x01..0x05 with ready=0, FifoDepth=4 -> level 4, one `overflow_o` pulse on 5th; drain yields 0x01,0x02,0x03,0x04 in order.
- FIFO full, ready asserted on the exact cycle 6th byte pushes -> no overflow, level stays 4, byte retained at tail.
- Reset asserted mid-frame with line held low 20 cycles after release -> no start/byte; line high then 0x55 sent -> 0x55 received.
